// File: rtl/dft_block_scheduler_if.sv
// -----------------------------------------------------------------------------
// dft_block_scheduler_if
// Bundles the two requester ports (request, length, direction, sample
// handshake) and the engine-side output stream of the DFT block scheduler.
//   slave  : the scheduler itself (consumes requests/samples, drives engine)
//   master : the environment (requesters and engine)
// Signal names carry the _i/_o suffix as seen from the scheduler.
// -----------------------------------------------------------------------------
interface dft_block_scheduler_if #(
    parameter int IN_W = 16
);
    logic        [1:0]      req_i;
    logic        [11:0]     len0_i;
    logic        [11:0]     len1_i;
    logic                   inv0_i;
    logic                   inv1_i;
    logic signed [IN_W-1:0] re0_i;
    logic signed [IN_W-1:0] im0_i;
    logic signed [IN_W-1:0] re1_i;
    logic signed [IN_W-1:0] im1_i;
    logic        [1:0]      src_val_i;
    logic        [1:0]      src_rdy_o;
    logic        [1:0]      gnt_o;
    logic        [1:0]      rej_o;
    logic                   block_sync_o;
    logic                   data_val_o;
    logic signed [IN_W-1:0] data_real_o;
    logic signed [IN_W-1:0] data_imag_o;
    logic        [11:0]     trans_len_o;
    logic                   inv_en_o;
    logic                   busy_o;

    modport slave (
        input  req_i, len0_i, len1_i, inv0_i, inv1_i,
               re0_i, im0_i, re1_i, im1_i, src_val_i,
        output src_rdy_o, gnt_o, rej_o, block_sync_o, data_val_o,
               data_real_o, data_imag_o, trans_len_o, inv_en_o, busy_o
    );

    modport master (
        output req_i, len0_i, len1_i, inv0_i, inv1_i,
               re0_i, im0_i, re1_i, im1_i, src_val_i,
        input  src_rdy_o, gnt_o, rej_o, block_sync_o, data_val_o,
               data_real_o, data_imag_o, trans_len_o, inv_en_o, busy_o
    );
endinterface

// File: rtl/dft_block_scheduler.sv
// -----------------------------------------------------------------------------
// dft_block_scheduler
// Arbitrates two sample sources onto one DFT/iDFT engine input. A requester
// asks for a block of trans_len samples; legal lengths (12..2048) are granted
// round-robin, illegal ones rejected. The granted source's samples are passed
// bit-exact to the engine through one register stage, with block_sync marking
// the first sample. MIN_GAP idle cycles separate consecutive blocks.
// Ports:
//   clk_sys   : clock, rising edge
//   rst_sys_n : asynchronous active-low reset
//   bus       : dft_block_scheduler_if.slave (requests, samples, engine stream)
// -----------------------------------------------------------------------------
module dft_block_scheduler #(
    parameter int IN_W    = 16,
    parameter int MIN_GAP = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    dft_block_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, STREAM, GAP} state_t;

    localparam logic [3:0]  GAP_LAST = 4'(MIN_GAP - 1);
    localparam logic [11:0] LEN_MIN  = 12'd12;
    localparam logic [11:0] LEN_MAX  = 12'd2048;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;     // requester served (granted or rejected) last
    logic        [11:0]     cnt_q, cnt_d;
    logic        [11:0]     len_q, len_d;
    logic                   inv_q, inv_d;
    logic        [3:0]      gap_q, gap_d;
    logic        [1:0]      gnt_q, gnt_d;
    logic        [1:0]      rej_q, rej_d;
    logic                   dval_q, sync_q;
    logic signed [IN_W-1:0] dre_q, dim_q;

    logic                   sel;
    logic        [11:0]     sel_len;
    logic                   sel_legal;
    logic                   xfer;

    // Round-robin pick: on contention the requester not served last wins.
    // last_q resets to 1 so requester 0 is favoured out of reset.
    always_comb begin
        if (bus.req_i == 2'b11) sel = ~last_q;
        else                    sel = bus.req_i[1];
    end

    assign sel_len   = sel ? bus.len1_i : bus.len0_i;
    assign sel_legal = (sel_len >= LEN_MIN) && (sel_len <= LEN_MAX);
    assign xfer      = (state_q == STREAM) && (owner_q ? bus.src_val_i[1] : bus.src_val_i[0]);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        inv_d   = inv_q;
        gap_d   = gap_q;
        gnt_d   = 2'b00;
        rej_d   = 2'b00;
        case (state_q)
            IDLE: begin
                // rej_q high means the rejected requester has not yet seen its
                // pulse and still holds req; skip one evaluation so the same
                // request is not rejected twice.
                if ((bus.req_i != 2'b00) && (rej_q == 2'b00)) begin
                    last_d = sel;
                    if (sel_legal) begin
                        owner_d = sel;
                        len_d   = sel_len;
                        inv_d   = sel ? bus.inv1_i : bus.inv0_i;
                        cnt_d   = 12'd0;
                        gnt_d   = sel ? 2'b10 : 2'b01;
                        state_d = GRANT;
                    end else begin
                        rej_d   = sel ? 2'b10 : 2'b01;
                    end
                end
            end
            GRANT: state_d = STREAM;
            STREAM: begin
                if (xfer) begin
                    cnt_d = cnt_q + 12'd1;
                    if (cnt_q == len_q - 12'd1) begin
                        gap_d   = 4'd0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            len_q   <= '0;
            inv_q   <= 1'b0;
            gap_q   <= '0;
            gnt_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            inv_q   <= inv_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            rej_q   <= rej_d;
        end
    end

    // Output stage: one register between an accepted sample and the engine.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            dval_q <= 1'b0;
            sync_q <= 1'b0;
            dre_q  <= '0;
            dim_q  <= '0;
        end else begin
            dval_q <= xfer;
            sync_q <= xfer && (cnt_q == 12'd0);
            if (xfer) begin
                dre_q <= owner_q ? bus.re1_i : bus.re0_i;
                dim_q <= owner_q ? bus.im1_i : bus.im0_i;
            end
        end
    end

    assign bus.src_rdy_o    = (state_q == STREAM) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.gnt_o        = gnt_q;
    assign bus.rej_o        = rej_q;
    assign bus.block_sync_o = sync_q;
    assign bus.data_val_o   = dval_q;
    assign bus.data_real_o  = dre_q;
    assign bus.data_imag_o  = dim_q;
    assign bus.trans_len_o  = len_q;
    assign bus.inv_en_o     = inv_q;
    assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_dft_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dft_block_scheduler
// Directed bench for dft_block_scheduler: reset state, single and contended
// requests, length boundaries, source bubbles, and reset in mid-block.
// -----------------------------------------------------------------------------
module tb_dft_block_scheduler;
    localparam int IN_W = 16;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    int   n_chk     = 0;
    int   n_fail    = 0;
    int   cyc       = 0;

    dft_block_scheduler_if #(.IN_W(IN_W)) bus ();

    dft_block_scheduler #(.IN_W(IN_W), .MIN_GAP(2)) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (bus)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},  32'(bus.src_rdy_o), 0);
        check({tag, "_gnt"},  32'(bus.gnt_o), 0);
        check({tag, "_rej"},  32'(bus.rej_o), 0);
        check({tag, "_sync"}, 32'(bus.block_sync_o), 0);
        check({tag, "_val"},  32'(bus.data_val_o), 0);
        check({tag, "_re"},   32'(bus.data_real_o), 0);
        check({tag, "_im"},   32'(bus.data_imag_o), 0);
        check({tag, "_len"},  32'(bus.trans_len_o), 0);
        check({tag, "_inv"},  32'(bus.inv_en_o), 0);
        check({tag, "_busy"}, 32'(bus.busy_o), 0);
    endtask

    // Caller raises req at a negedge; returns at a negedge.
    task automatic reject_case(input int who, input logic [11:0] len);
        if (who == 1) bus.len1_i = len; else bus.len0_i = len;
        bus.req_i = oh(who);
        @(negedge clk_sys);
        check("rej_pulse", 32'(bus.rej_o), 32'(oh(who)));
        check("rej_no_gnt", 32'(bus.gnt_o), 0);
        check("rej_no_busy", 32'(bus.busy_o), 0);
        bus.req_i = 2'b00;
        @(negedge clk_sys);
        check("rej_one_cycle", 32'(bus.rej_o), 0);
        check("rej_no_val", 32'(bus.data_val_o), 0);
        check("rej_still_idle", 32'(bus.busy_o), 0);
    endtask

    // Waits for the grant of requester `who`, streams one block and checks
    // the engine-side stream against a queue of the samples it offered.
    task automatic serve(input int who, input int len, input bit inv, input bit rnd,
                         input int abort_at, output int first_cyc, output int last_cyc);
        logic signed [IN_W-1:0] qr[$];
        logic signed [IN_W-1:0] qi[$];
        logic signed [IN_W-1:0] r, im, er, ei;
        logic [1:0] vals;
        bit   got;
        bit   v;
        int   nout, nacc;
        got = 0; nout = 0; nacc = 0; first_cyc = 0; last_cyc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_sys);
            if (bus.gnt_o != 2'b00) got = 1;
        end
        check("gnt_seen", 32'(got), 1);
        check("gnt_o", 32'(bus.gnt_o), 32'(oh(who)));
        check("trans_len_o", 32'(bus.trans_len_o), 32'(len));
        check("inv_en_o", 32'(bus.inv_en_o), 32'(inv));
        check("busy_grant", 32'(bus.busy_o), 1);
        bus.req_i[who] = 1'b0;
        for (int b = 0; b < len * 6 + 40 && nout < len; b++) begin
            v  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            r  = IN_W'($urandom());
            im = IN_W'($urandom());
            if (nacc == 0) begin
                r  = {1'b1, {(IN_W-1){1'b0}}};
                im = {1'b0, {(IN_W-1){1'b1}}};
            end
            vals[who]     = v;
            vals[1 - who] = 1'b1;
            bus.src_val_i = vals;
            if (who == 1) begin
                bus.re1_i = r; bus.im1_i = im;
                bus.re0_i = ~r; bus.im0_i = ~im;
            end else begin
                bus.re0_i = r; bus.im0_i = im;
                bus.re1_i = ~r; bus.im1_i = ~im;
            end
            if (v && bus.src_rdy_o[who]) begin
                qr.push_back(r);
                qi.push_back(im);
                nacc++;
            end
            @(negedge clk_sys);
            check("rdy_other", 32'(bus.src_rdy_o[1 - who]), 0);
            if (bus.data_val_o) begin
                check("block_sync", 32'(bus.block_sync_o), 32'(nout == 0));
                if (qr.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    er = qr.pop_front();
                    ei = qi.pop_front();
                    check("data_real", 32'(bus.data_real_o), 32'(er));
                    check("data_imag", 32'(bus.data_imag_o), 32'(ei));
                end
                if (nout == 0) first_cyc = cyc;
                last_cyc = cyc;
                nout++;
            end else begin
                check("sync_idle", 32'(bus.block_sync_o), 0);
            end
            if (abort_at > 0 && nout == abort_at) break;
        end
        if (abort_at == 0) begin
            check("out_count", 32'(nout), 32'(len));
            check("acc_count", 32'(nacc), 32'(len));
            check("rdy_after_last", 32'(bus.src_rdy_o), 0);
            @(negedge clk_sys);
            check("gap1_busy", 32'(bus.busy_o), 1);
            check("gap1_no_val", 32'(bus.data_val_o), 0);
            @(negedge clk_sys);
            check("gap_end_idle", 32'(bus.busy_o), 0);
            check("len_hold", 32'(bus.trans_len_o), 32'(len));
            check("inv_hold", 32'(bus.inv_en_o), 32'(inv));
            bus.src_val_i = 2'b00;
        end
    endtask

    initial begin
        int f0, l0, f1, l1;
        bus.req_i = 2'b00; bus.len0_i = '0; bus.len1_i = '0;
        bus.inv0_i = 1'b0; bus.inv1_i = 1'b0;
        bus.re0_i = '0; bus.im0_i = '0; bus.re1_i = '0; bus.im1_i = '0;
        bus.src_val_i = 2'b00;

        // Reset state, with requests and valids already asserted
        repeat (3) @(negedge clk_sys);
        bus.req_i = 2'b11; bus.src_val_i = 2'b11;
        bus.len0_i = 12'd16; bus.len1_i = 12'd24;
        bus.inv0_i = 1'b0;   bus.inv1_i = 1'b1;
        @(negedge clk_sys);
        check_all_zero("reset");
        bus.src_val_i = 2'b00;
        rst_sys_n = 1'b1;

        // Contention from reset: requester 0, then requester 1 after the gap
        serve(0, 16, 1'b0, 1'b0, 0, f0, l0);
        serve(1, 24, 1'b1, 1'b0, 0, f1, l1);
        check("gap_between_blocks", 32'((f1 - l0) >= 4), 1);

        // Single request, minimum length, iDFT
        bus.len0_i = 12'd12; bus.inv0_i = 1'b1; bus.req_i = 2'b01;
        serve(0, 12, 1'b1, 1'b0, 0, f0, l0);

        // Length boundaries: 11 and 4095 rejected, then a legal request
        reject_case(0, 12'd11);
        reject_case(1, 12'd4095);
        bus.len0_i = 12'd12; bus.inv0_i = 1'b0; bus.req_i = 2'b01;
        serve(0, 12, 1'b0, 1'b0, 0, f0, l0);

        // Maximum length with random source bubbles
        bus.len1_i = 12'd2048; bus.inv1_i = 1'b0; bus.req_i = 2'b10;
        serve(1, 2048, 1'b0, 1'b1, 0, f0, l0);

        // Reset after 100 of 1200 samples
        bus.len0_i = 12'd1200; bus.inv0_i = 1'b1; bus.req_i = 2'b01;
        serve(0, 1200, 1'b1, 1'b0, 100, f0, l0);
        rst_sys_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk_sys);
        check("in_reset_val", 32'(bus.data_val_o), 0);
        rst_sys_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("post_reset_val", 32'(bus.data_val_o), 0);
        check("post_reset_busy", 32'(bus.busy_o), 0);
        bus.src_val_i = 2'b00;

        // Both request after reset: pointer favours requester 0 again
        bus.len0_i = 12'd20; bus.inv0_i = 1'b0;
        bus.len1_i = 12'd33; bus.inv1_i = 1'b1;
        bus.req_i = 2'b11;
        serve(0, 20, 1'b0, 1'b0, 0, f0, l0);
        serve(1, 33, 1'b1, 1'b1, 0, f1, l1);
        check("gap_after_reset", 32'((f1 - l0) >= 4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dft_block_scheduler.md
DFT_BLOCK_SCHEDULER -- requirements
Module: dft_block_scheduler

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning sample width per I/Q component.
REQ-002 The block SHALL have parameter MIN_GAP, default 2, meaning idle cycles enforced between consecutive output blocks (range 1..15).
REQ-003 clk_sys  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_sys_n  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  2  per-requester block request, level, held until gnt_o or rej_o for that requester.
REQ-006 len0_i, len1_i  input  12 each  per-requester transform length, valid while the matching req_i bit is high.
REQ-007 inv0_i, inv1_i  input  1 each  per-requester direction: 0 = DFT, 1 = iDFT.
REQ-008 re0_i, im0_i, re1_i, im1_i  input  IN_W each, signed  per-requester sample.
REQ-009 src_val_i  input  2  per-requester sample valid.
REQ-010 src_rdy_o  output  2  per-requester sample ready; a sample transfers when src_val_i[n] and src_rdy_o[n] are both 1.
REQ-011 gnt_o  output  2  one-cycle grant pulse.
REQ-012 rej_o  output  2  one-cycle reject pulse for an illegal length.
REQ-013 block_sync_o  output  1  to engine: marks the first sample of a block.
REQ-014 data_val_o  output  1  to engine: sample valid.
REQ-015 data_real_o, data_imag_o  output  IN_W each, signed  to engine: sample.
REQ-016 trans_len_o  output  12  to engine: latched length of the current block.
REQ-017 inv_en_o  output  1  to engine: latched direction of the current block.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, GRANT, STREAM and GAP.
REQ-020 In IDLE with any req_i bit set, the block SHALL select a requester round-robin: if both bits are set, the requester not granted or rejected last wins; after reset, requester 0 wins.
REQ-021 The selected requester's length SHALL be legal if it lies in 12..2048 inclusive; otherwise the block SHALL pulse rej_o[n] for 1 cycle, update the round-robin pointer, and stay in IDLE.
REQ-022 For a legal length, the block SHALL latch len and inv into trans_len_o and inv_en_o, pulse gnt_o[n] for 1 cycle, and enter GRANT.
REQ-023 GRANT SHALL last exactly 1 cycle and then go to STREAM.
REQ-024 In STREAM, src_rdy_o SHALL be 1 only for the granted requester, and 0 for the other.
REQ-025 Each transfer SHALL appear on data_val_o, data_real_o and data_imag_o exactly 1 cycle later (registered); data_val_o SHALL be 0 in cycles with no transfer, so source bubbles pass through.
REQ-026 block_sync_o SHALL be 1 together with data_val_o for the first sample of the block only.
REQ-027 A 12-bit sample counter SHALL clear on grant and increment per transfer.
REQ-028 On the transfer with count == trans_len_o-1, src_rdy_o SHALL drop in the next cycle and the FSM SHALL enter GAP; no more than trans_len_o samples SHALL be accepted per block.
REQ-029 GAP SHALL last exactly MIN_GAP cycles and then return to IDLE.
REQ-030 trans_len_o and inv_en_o SHALL hold until the next grant.
REQ-031 Requests arriving during GRANT, STREAM or GAP SHALL be evaluated in the next IDLE cycle.
REQ-032 req_i bits SHALL be ignored outside IDLE.
REQ-033 src_val_i on a non-granted requester SHALL be ignored.
REQ-034 The block SHALL perform no arithmetic on data; samples SHALL pass through bit-exact.

Reset
REQ-035 While rst_sys_n is low, all outputs SHALL be 0, the FSM SHALL be in IDLE, the counter SHALL be 0 and the round-robin pointer SHALL favour requester 0.
REQ-036 On a reset asserted mid-block, the partial block SHALL be abandoned and no further data_val_o SHALL be emitted until a new grant.

Verification
REQ-037 Single request, req_i=01, len0=12, inv0=1, continuous valid -> gnt_o=01 pulse; 12 data_val_o cycles with block_sync_o on the first; trans_len_o=12; inv_en_o=1; 2 GAP cycles; busy_o low.
REQ-038 Both requesting from reset, len0=16, len1=24 -> requester 0 block, then requester 1 block, starting no earlier than 3 cycles (GRANT + MIN_GAP) after the first block's last sample.
REQ-039 Illegal length, req_i=10, len1=4095 -> rej_o=10 pulse, no gnt_o, no data_val_o; a following legal req_i=01 is granted.
REQ-040 Bubbles: len=2048 with src_val_i toggling randomly -> exactly 2048 data_val_o, bit-exact order, src_rdy_o low after the last sample.
REQ-041 Reset mid-block, rst_sys_n low after 100 of 1200 samples -> all outputs 0; after release, a new request is granted cleanly and produces a full block.
